sseg_scan_mux: RTL

Time-multiplexed driver for the four-digit, active-low seven-segment display. It consumes four per-digit segment patterns from pattern generators such as the rotating-square and counter-display stages, and scans them onto the shared anode/segment pins. Inputs are latched only at frame boundaries, so a producer updating mid-frame never tears the display. A dead-time gap at each digit switch suppresses ghosting, and an optional per-digit dimming stage is available.

---
 rtl/sseg_scan_mux.sv | 101 ++++++++++
 1 files changed

// File: rtl/sseg_scan_mux.sv
// sseg_scan_mux: four-digit active-low seven-segment scan driver with frame-latched
// inputs and a blank dead-time at each digit switch. Define SSEG_DIM_EN for per-digit dimming.
module sseg_scan_mux #(
    parameter int REFRESH_BITS = 18,
    parameter int DEAD         = 256
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in0,
    input  logic [7:0] in1,
    input  logic [7:0] in2,
    input  logic [7:0] in3,
    input  logic [3:0] blank,
`ifdef SSEG_DIM_EN
    input  logic [3:0] bright,
`endif
    output logic [3:0] an,
    output logic [7:0] sseg,
    output logic       frame_tick
);

    localparam int PW = REFRESH_BITS - 2;
    localparam logic [PW-1:0] DEAD_P = PW'(DEAD);

    logic [REFRESH_BITS-1:0] q;
    logic [1:0]              slot;
    logic [PW-1:0]           phase;
    logic                    frame_end;

    logic [7:0]              sh_pat [4];
    logic [3:0]              sh_blank;
`ifdef SSEG_DIM_EN
    logic [3:0]              sh_bright;
`endif

    logic                    dim_ok;
    logic                    lit;
    logic [3:0]              an_d;
    logic [7:0]              sseg_d;

    assign slot      = q[REFRESH_BITS-1 -: 2];
    assign phase     = q[PW-1:0];
    assign frame_end = &q;

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else begin
            q <= q + 1'b1;
        end
    end

    // Shadows change only on the last cycle of a frame so a frame never tears.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                sh_pat[i] <= 8'hFF;
            end
            sh_blank <= 4'b0000;
`ifdef SSEG_DIM_EN
            sh_bright <= 4'hF;
`endif
        end else if (frame_end) begin
            sh_pat[0] <= in0;
            sh_pat[1] <= in1;
            sh_pat[2] <= in2;
            sh_pat[3] <= in3;
            sh_blank  <= blank;
`ifdef SSEG_DIM_EN
            sh_bright <= bright;
`endif
        end
    end

    always_comb begin
        dim_ok = 1'b1;
`ifdef SSEG_DIM_EN
        dim_ok = (phase[PW-1 -: 4] <= sh_bright[slot]);
`endif
        lit    = (phase >= DEAD_P) && !sh_blank[slot] && dim_ok;
        an_d   = 4'b1111;
        sseg_d = 8'hFF;
        if (lit) begin
            an_d   = ~(4'b0001 << slot);
            sseg_d = sh_pat[slot];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            an         <= 4'b1111;
            sseg       <= 8'hFF;
            frame_tick <= 1'b0;
        end else begin
            an         <= an_d;
            sseg       <= sseg_d;
            frame_tick <= frame_end;
        end
    end

endmodule
